// File: rtl/program_loader.sv
// Framed byte-stream loader for the 256-byte instruction memory.
// Frame: SYNC, start address, length (0 = 256), payload, checksum; holds the CPU while loading or after an error.
module program_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

    // Modular byte sum used for the frame checksum.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        csum_add = acc + b;
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  addr_ptr_r, addr_ptr_s;
    logic [8:0]  remain_r, remain_s;
    logic [7:0]  sum_r, sum_s;
    logic        err_flag_r, err_flag_s;
    logic [15:0] tmo_cnt_r, tmo_cnt_s;
    logic        rx_ready_r;
    logic        mem_we_r, mem_we_s;
    logic [7:0]  mem_addr_r, mem_addr_s;
    logic [7:0]  mem_wdata_r, mem_wdata_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic        busy_r, cpu_hold_r;
    logic        accept_s;

    assign accept_s = rx_valid & rx_ready_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_s     = state_r;
        addr_ptr_s  = addr_ptr_r;
        remain_s    = remain_r;
        sum_s       = sum_r;
        err_flag_s  = err_flag_r;
        tmo_cnt_s   = tmo_cnt_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        done_s      = 1'b0;
        err_s       = 1'b0;

        if (state_r == ST_IDLE) begin
            tmo_cnt_s = 16'd0;
            if (accept_s && (rx_data == SYNC_BYTE)) begin
                state_s    = ST_ADDR;
                sum_s      = 8'h00;
                err_flag_s = 1'b0;
            end else begin
                state_s = ST_IDLE;
            end
        end else if (tmo_cnt_r == TMO_LIMIT) begin
            // Timeout wins over a byte arriving in the same cycle; that byte is dropped.
            err_s      = 1'b1;
            err_flag_s = 1'b1;
            tmo_cnt_s  = 16'd0;
            state_s    = ST_IDLE;
        end else if (accept_s) begin
            tmo_cnt_s = 16'd0;
            sum_s     = csum_add(sum_r, rx_data);
            case (state_r)
                ST_ADDR: begin
                    addr_ptr_s = rx_data;
                    state_s    = ST_LEN;
                end
                ST_LEN: begin
                    remain_s = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    state_s  = ST_DATA;
                end
                ST_DATA: begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = addr_ptr_r;
                    mem_wdata_s = rx_data;
                    addr_ptr_s  = addr_ptr_r + 8'd1;
                    remain_s    = remain_r - 9'd1;
                    if (remain_r == 9'd1) begin
                        state_s = ST_CSUM;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (sum_s == 8'h00) begin
                        done_s = 1'b1;
                    end else begin
                        err_s      = 1'b1;
                        err_flag_s = 1'b1;
                    end
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            tmo_cnt_s = tmo_cnt_r + 16'd1;
        end
    end

    // Frame context and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_ptr_r  <= 8'h00;
            remain_r    <= 9'd0;
            sum_r       <= 8'h00;
            err_flag_r  <= 1'b0;
            tmo_cnt_r   <= 16'd0;
            rx_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 8'h00;
            mem_wdata_r <= 8'h00;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            cpu_hold_r  <= 1'b0;
        end else begin
            addr_ptr_r  <= addr_ptr_s;
            remain_r    <= remain_s;
            sum_r       <= sum_s;
            err_flag_r  <= err_flag_s;
            tmo_cnt_r   <= tmo_cnt_s;
            rx_ready_r  <= 1'b1;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            done_r      <= done_s;
            err_r       <= err_s;
            busy_r      <= (state_s != ST_IDLE);
            cpu_hold_r  <= (state_s != ST_IDLE) | err_flag_s;
        end
    end

    assign rx_ready  = rx_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_hold  = cpu_hold_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that writes instruction bytes into the 256-byte instruction memory through its write port. It sits between a byte source (UART receiver or testbench driver) and the instruction memory, parses a framed download (sync, start address, length, payload, checksum) and holds the CPU in reset while a download is in progress. It is the writer for the instruction memory's read-only fetch path.

## Interface

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000, maximum idle cycles allowed between bytes inside a frame (range 2..65535).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_valid  input  1  rx_data holds a byte this cycle; the byte is consumed when rx_valid && rx_ready.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader can accept a byte; 0 only while rst is high, otherwise 1.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per payload byte.
- mem_addr  output  8  instruction memory write address.
- mem_wdata  output  8  instruction memory write data.
- cpu_hold  output  1  holds the CPU (PC/fetch) in reset.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse: frame completed with a good checksum.
- err  output  1  one-cycle pulse: checksum mismatch or timeout.

## Operation

- States: IDLE, ADDR, LEN, DATA, CSUM.
- IDLE: bytes other than SYNC_BYTE are discarded; SYNC_BYTE -> ADDR, clear the sum, error flag and timeout counter.
- ADDR: byte -> addr_ptr, added to the sum -> LEN.
- LEN: byte -> remaining count; 0 means 256 bytes. Added to the sum -> DATA.
- DATA: each byte is written to mem[addr_ptr], added to the sum, addr_ptr increments and wraps 8'hFF -> 8'h00, remaining count decrements. After the last byte -> CSUM.
- CSUM: byte is added to the sum. A final sum of 8'h00 (mod 256) pulses done; any other value pulses err and sets the sticky error flag. Either way the next state is IDLE.
- Checksum rule: addr + len + all payload + csum ≡ 0 mod 256. The sender transmits csum = -(addr+len+payload) mod 256.
- Payload is written through to memory as it arrives. It is not rolled back on error.
- Timeout: outside IDLE, a counter increments on every cycle with no accepted byte and clears on every accepted byte. When it reaches TIMEOUT: pulse err, set the sticky error flag, return to IDLE. A byte accepted on the same cycle is discarded.
- cpu_hold = busy | sticky error flag. The error flag clears only on the next accepted SYNC_BYTE or on rst. cpu_hold therefore stays high after a bad frame until a new frame starts and completes cleanly.
- A SYNC_BYTE value received outside IDLE is treated as ordinary data; it does not resynchronise the frame.

## Timing

- Reset values: rx_ready=0 during rst, then 1; mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0; state IDLE.
- All outputs are registered.
- mem_we/mem_addr/mem_wdata are valid in the cycle after the payload byte is accepted; back-to-back bytes give back-to-back writes.
- done/err assert in the cycle after the checksum byte is accepted. busy and cpu_hold drop in the same cycle as done (cpu_hold stays high with err).
- busy rises the cycle after SYNC_BYTE is accepted.
- rst asserted mid-frame: the next cycle is IDLE, all outputs at reset values, and the partial payload already written remains in memory.
- Throughput: one byte per cycle; a minimum frame with N payload bytes takes N+4 accepted bytes.

## Test plan

- Good frame A5,10,03,C0,05,00,csum=28: writes mem[10]=C0, mem[11]=05, mem[12]=00 on consecutive cycles; done pulses once; cpu_hold returns to 0.
- Bad checksum (same frame, csum=29): the three writes still occur; err pulses; cpu_hold stays 1. A following good frame clears it and pulses done.
- Wrap and length 0: A5,FE,00, then 256 payload bytes 0..255, correct csum. Writes mem[FE]=00, mem[FF]=01, mem[00]=02 … mem[FD]=FF, then done.
- Timeout (TIMEOUT=8): A5,20, then TIMEOUT idle cycles -> err pulses, busy=0, no write is issued. A subsequent byte 20 is ignored in IDLE.
- Leading garbage 00,FF,3C before A5 is ignored, and an A5 inside the payload is written as data. Check both with a valid frame.
- rst asserted after two of four payload bytes: the first two writes are present, no done/err is generated, and every output is at its reset value on the following cycle.
